// File: rtl/mm_pkg.sv
// mm_pkg: shared encodings and defaults for the mm_tile_sched tile sequencer.
//   mm_mode_e  : INT8 / INT4 run a MAX pass before CALC, INT4_VSQ goes straight to CALC
//   mm_state_e : sequencer states
//   *_DEF      : default geometry used by mm_tile_sched
package mm_pkg;
    typedef enum logic [1:0] {
        MODE_INT8     = 2'd0,
        MODE_INT4     = 2'd1,
        MODE_INT4_VSQ = 2'd2
    } mm_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAX,
        ST_CALC,
        ST_FLUSH
    } mm_state_e;

    localparam int VL_DEF     = 8;
    localparam int AD_DEF     = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int ADDR_W_DEF = 12;
    localparam int DIM_W_DEF  = 8;
    localparam int RD_LAT_DEF = 2;
endpackage

// File: rtl/mm_acc_bank.sv
// mm_acc_bank: one AD x (ACC_W*VL) accumulator bank with a full flag.
//   i_clk, i_rst_n      : clock, async active-low reset (clears the full flag only)
//   i_we/i_waddr/i_wdata: accumulate lane products into row i_waddr
//   i_first             : restart the row at zero instead of adding to it
//   i_last              : this write completes the tile, bank becomes full
//   i_raddr/o_rdata     : combinational drain read port
//   i_clr               : tile drained, bank becomes empty
//   o_full              : bank holds a finished, undrained tile
module mm_acc_bank #(
    parameter int VL    = 8,
    parameter int AD    = 16,
    parameter int ACC_W = 24
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [$clog2(AD)-1:0]    i_waddr,
    input  logic                     i_first,
    input  logic                     i_last,
    input  logic [VL*ACC_W-1:0]      i_wdata,
    input  logic [$clog2(AD)-1:0]    i_raddr,
    output logic [VL*ACC_W-1:0]      o_rdata,
    input  logic                     i_clr,
    output logic                     o_full
);
    logic [VL*ACC_W-1:0] mem [AD];
    logic [VL*ACC_W-1:0] cur, sum;

    assign cur     = mem[i_waddr];
    assign o_rdata = mem[i_raddr];

    // lane-wise add, each lane wraps modulo 2^ACC_W
    always_comb begin
        sum = '0;
        for (int l = 0; l < VL; l++)
            sum[l*ACC_W +: ACC_W] = (i_first ? '0 : cur[l*ACC_W +: ACC_W]) + i_wdata[l*ACC_W +: ACC_W];
    end

    always_ff @(posedge i_clk)
        if (i_we) mem[i_waddr] <= sum;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) o_full <= 1'b0;
        else          o_full <= (o_full && !i_clr) || (i_we && i_last);
endmodule

// File: rtl/mm_tile_sched.sv
// mm_tile_sched: matrix-multiply tile sequencer with ping-pong accumulators and PPU drain.
//   i_clk, i_rst_n                : clock, async active-low reset
//   i_start, i_mode               : job start (IDLE only), operand mode
//   i_row_tiles/col_tiles/k_steps : job dimensions, i_n_stride: B row pitch
//   o_a_addr, o_b_addr, o_rd_en   : RAM address issue
//   i_prod                        : lane products, RD_LAT cycles after issue
//   o_max_pass                    : MAX pass in progress
//   o_acc_data/valid, i_ppu_ready : drain handshake
//   o_bias_req, o_tile_done, o_mtrx_done, o_busy : status pulses / level
//   Optional MM_PERF_CNT_EN adds o_cyc_cnt and o_stall_cnt.
module mm_tile_sched import mm_pkg::*; #(
    parameter int VL     = VL_DEF,
    parameter int AD     = AD_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [DIM_W-1:0]    i_row_tiles,
    input  logic [DIM_W-1:0]    i_col_tiles,
    input  logic [DIM_W-1:0]    i_k_steps,
    input  logic [ADDR_W-1:0]   i_n_stride,
    output logic [ADDR_W-1:0]   o_a_addr,
    output logic [ADDR_W-1:0]   o_b_addr,
    output logic                o_rd_en,
    input  logic [ACC_W*VL-1:0] i_prod,
    output logic                o_max_pass,
    output logic [ACC_W*VL-1:0] o_acc_data,
    output logic                o_acc_valid,
    input  logic                i_ppu_ready,
    output logic                o_bias_req,
    output logic                o_tile_done,
    output logic                o_busy,
`ifdef MM_PERF_CNT_EN
    output logic [31:0]         o_cyc_cnt,
    output logic [31:0]         o_stall_cnt,
`endif
    output logic                o_mtrx_done
);
    localparam int BW = $clog2(AD);

    mm_state_e st, st_nx;
    logic [DIM_W-1:0]  rows, cols, ks, row, col, k;
    logic [ADDR_W-1:0] nst;
    logic [BW-1:0]     b, db;
    logic              wsel, rsel, drn;
    logic              issuing, stall, adv, last_b, last_k, last_c, last_r, last_iss, beat, tile_end;
    logic [1:0]        full, we, clr;
    logic [RD_LAT-1:0] p_en, p_bank, p_first, p_last;
    logic [BW-1:0]     p_b [RD_LAT];
    logic [VL*ACC_W-1:0] rdata [2];

    assign issuing  = st == ST_MAX || st == ST_CALC;
    // a new tile may not start filling a bank that still waits to be drained
    assign stall    = st == ST_CALC && k == '0 && b == '0 && full[wsel];
    assign adv      = issuing && !stall;
    assign last_b   = b == BW'(AD - 1);
    assign last_k   = k == ks - DIM_W'(1);
    assign last_c   = col == cols - DIM_W'(1);
    assign last_r   = row == rows - DIM_W'(1);
    assign last_iss = adv && last_b && last_k && last_c && last_r;
    assign beat     = drn && i_ppu_ready;
    assign tile_end = beat && db == BW'(AD - 1);

    assign o_rd_en     = adv;
    assign o_a_addr    = ADDR_W'(k) + ADDR_W'(row) * ADDR_W'(ks);
    assign o_b_addr    = ADDR_W'(b) + ADDR_W'(k) * nst + ADDR_W'(col) * ADDR_W'(AD);
    assign o_max_pass  = st == ST_MAX;
    assign o_busy      = st != ST_IDLE;
    assign o_acc_valid = drn;
    assign o_acc_data  = drn ? rdata[rsel] : '0;

    assign we  = {2{p_en[RD_LAT-1]}} & {p_bank[RD_LAT-1], ~p_bank[RD_LAT-1]};
    assign clr = {2{tile_end}} & {rsel, ~rsel};

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) st <= ST_IDLE;
        else          st <= st_nx;

    always_comb begin
        st_nx = st;
        if (st == ST_IDLE && i_start) st_nx = (i_mode == MODE_INT4_VSQ) ? ST_CALC : ST_MAX;
        if (last_iss) st_nx = (st == ST_MAX) ? ST_CALC : ST_FLUSH;
        if (st == ST_FLUSH && full == 2'b00 && p_en == '0 && !drn) st_nx = ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {rows, cols, ks, row, col, k} <= '0;
            nst <= '0;
            b <= '0;
            db <= '0;
            {wsel, rsel, drn} <= '0;
            {p_en, p_bank, p_first, p_last} <= '0;
            for (int i = 0; i < RD_LAT; i++) p_b[i] <= '0;
            {o_bias_req, o_tile_done, o_mtrx_done} <= '0;
        end else begin
            if (st == ST_IDLE && i_start) begin
                rows <= i_row_tiles;
                cols <= i_col_tiles;
                ks   <= i_k_steps;
                nst  <= i_n_stride;
            end
            if (adv) begin
                b <= last_b ? '0 : b + 1'b1;
                if (last_b) k <= last_k ? '0 : k + 1'b1;
                if (last_b && last_k) col <= last_c ? '0 : col + 1'b1;
                if (last_b && last_k) wsel <= wsel ^ (st == ST_CALC);
                if (last_b && last_k && last_c) row <= last_r ? '0 : row + 1'b1;
            end
            for (int i = RD_LAT - 1; i > 0; i--) begin
                p_en[i]    <= p_en[i-1];
                p_bank[i]  <= p_bank[i-1];
                p_first[i] <= p_first[i-1];
                p_last[i]  <= p_last[i-1];
                p_b[i]     <= p_b[i-1];
            end
            p_en[0]    <= adv && st == ST_CALC;
            p_bank[0]  <= wsel;
            p_first[0] <= k == '0;
            p_last[0]  <= last_b && last_k;
            p_b[0]     <= b;
            // drain starts one cycle after the bank turns full so bias_req leads the first beat
            o_bias_req <= p_en[RD_LAT-1] && p_last[RD_LAT-1];
            drn <= drn ? !tile_end : full[rsel];
            if (beat) db <= (db == BW'(AD - 1)) ? '0 : db + 1'b1;
            if (tile_end) rsel <= ~rsel;
            o_tile_done <= tile_end;
            // the final tile is the one drained once issue is over and nothing else is pending
            o_mtrx_done <= tile_end && st == ST_FLUSH && !full[~rsel] && p_en == '0;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        mm_acc_bank #(.VL(VL), .AD(AD), .ACC_W(ACC_W)) u_bank (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_we    (we[g]),
            .i_waddr (p_b[RD_LAT-1]),
            .i_first (p_first[RD_LAT-1]),
            .i_last  (p_last[RD_LAT-1]),
            .i_wdata (i_prod),
            .i_raddr (db),
            .o_rdata (rdata[g]),
            .i_clr   (clr[g]),
            .o_full  (full[g])
        );
    end

`ifdef MM_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cyc_cnt   <= '0;
            o_stall_cnt <= '0;
        end else if (st == ST_IDLE && i_start) begin
            o_cyc_cnt   <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (st != ST_IDLE && o_cyc_cnt != '1) o_cyc_cnt <= o_cyc_cnt + 1'b1;
            if (stall && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mm_tile_sched.sv
// tb_mm_tile_sched: randomized self-checking bench for mm_tile_sched against a tile-level model.
module tb_mm_tile_sched;
    localparam int VL = 8, AD = 16, ACC_W = 24, ADDR_W = 12, DIM_W = 8, RD_LAT = 2;
    localparam int PW = VL * ACC_W;

    logic clk = 0, rst_n = 0, start = 0, rdy = 1;
    logic [1:0] mode = 0;
    logic [DIM_W-1:0] rt = 0, ct = 0, kt = 0;
    logic [ADDR_W-1:0] ns = 0;
    logic [PW-1:0] prod = '0;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic rd_en, max_pass, acc_valid, bias_req, tile_done, busy, mtrx_done;
    logic [PW-1:0] acc_data;
`ifdef MM_PERF_CNT_EN
    logic [31:0] cyc_cnt, stall_cnt;
`endif

    mm_tile_sched #(.VL(VL), .AD(AD), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .RD_LAT(RD_LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
        .i_row_tiles(rt), .i_col_tiles(ct), .i_k_steps(kt), .i_n_stride(ns),
        .o_a_addr(a_addr), .o_b_addr(b_addr), .o_rd_en(rd_en), .i_prod(prod),
        .o_max_pass(max_pass), .o_acc_data(acc_data), .o_acc_valid(acc_valid),
        .i_ppu_ready(rdy), .o_bias_req(bias_req), .o_tile_done(tile_done), .o_busy(busy),
`ifdef MM_PERF_CNT_EN
        .o_cyc_cnt(cyc_cnt), .o_stall_cnt(stall_cnt),
`endif
        .o_mtrx_done(mtrx_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [ADDR_W-1:0] a; logic [ADDR_W-1:0] b; logic mx; } iss_t;
    iss_t iss_q[$];
    logic [PW-1:0] beat_q[$];
    int nchk = 0, nerr = 0, cyc = 0, rm = 0, gen = 0, slot;
    int n_tdone = 0, n_mdone = 0, n_bias = 0, n_beats = 0, n_max = 0;
    logic [31:0] seed = 0;
    logic [ACC_W-1:0] cval = 0;
    logic [PW-1:0] sp_val [8];
    logic sp_ok [8];
    iss_t mon_e;
    logic [PW-1:0] mon_p, prev_data = '0;
    logic prev_valid = 0, prev_rdy = 0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] pf(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input int l);
        logic [31:0] v;
        if (gen == 1) return cval;
        if (gen == 2) return a[0] ? 24'h800001 : 24'h7FFFFF;
        v = (32'(a) * 32'h9E3779B1) ^ (32'(b) * 32'h85EBCA6B) ^ (32'(l + 1) * 32'hC2B2AE35) ^ seed;
        v = v ^ (v >> 15);
        return v[ACC_W-1:0];
    endfunction

    function automatic logic [PW-1:0] pvec(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        logic [PW-1:0] v = '0;
        for (int l = 0; l < VL; l++) v[l*ACC_W +: ACC_W] = pf(a, b, l);
        return v;
    endfunction

    // expected issue order and drained tiles, straight from the address formulas and the sum over k
    task automatic start_job(input logic [1:0] md, input int r, input int c, input int k, input int n);
        logic [PW-1:0] s;
        logic [ADDR_W-1:0] a, bb;
        iss_q.delete();
        beat_q.delete();
        {n_tdone, n_mdone, n_bias, n_beats, n_max} = '0;
        for (int p = (md == 2) ? 1 : 0; p < 2; p++)
            for (int ri = 0; ri < r; ri++)
                for (int ci = 0; ci < c; ci++)
                    for (int ki = 0; ki < k; ki++)
                        for (int bi = 0; bi < AD; bi++)
                            iss_q.push_back('{a: ADDR_W'(ki + ri * k), b: ADDR_W'(bi + ki * n + ci * AD), mx: p == 0});
        for (int ri = 0; ri < r; ri++)
            for (int ci = 0; ci < c; ci++)
                for (int bi = 0; bi < AD; bi++) begin
                    s = '0;
                    for (int ki = 0; ki < k; ki++) begin
                        a  = ADDR_W'(ki + ri * k);
                        bb = ADDR_W'(bi + ki * n + ci * AD);
                        for (int l = 0; l < VL; l++) s[l*ACC_W +: ACC_W] += pf(a, bb, l);
                    end
                    beat_q.push_back(s);
                end
        @(posedge clk); #1;
        mode = md; rt = DIM_W'(r); ct = DIM_W'(c); kt = DIM_W'(k); ns = ADDR_W'(n); start = 1;
        @(posedge clk); #1;
        start = 0;
        // dimension inputs are don't-care once the job is running
        rt = DIM_W'($urandom); ct = DIM_W'($urandom); kt = DIM_W'($urandom); ns = ADDR_W'($urandom);
    endtask

    task automatic wait_idle(input int lim);
        int i = 0;
        while (busy && i < lim) begin
            @(posedge clk); #1;
            i++;
        end
        check("idle_timeout", PW'(busy), PW'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic end_checks(input logic [1:0] md, input int r, input int c, input int k);
        check("issues_left", PW'(iss_q.size()), PW'(0));
        check("beats_left", PW'(beat_q.size()), PW'(0));
        check("tile_done_cnt", PW'(n_tdone), PW'(r * c));
        check("bias_req_cnt", PW'(n_bias), PW'(r * c));
        check("mtrx_done_cnt", PW'(n_mdone), PW'(1));
        check("max_issue_cnt", PW'(n_max), PW'((md == 2) ? 0 : r * c * k * AD));
    endtask

    task automatic zero_checks();
        check("rst_rd_en", PW'(rd_en), PW'(0));
        check("rst_busy", PW'(busy), PW'(0));
        check("rst_acc_valid", PW'(acc_valid), PW'(0));
        check("rst_acc_data", acc_data, PW'(0));
        check("rst_a_addr", PW'(a_addr), PW'(0));
        check("rst_b_addr", PW'(b_addr), PW'(0));
        check("rst_max_pass", PW'(max_pass), PW'(0));
        check("rst_bias_req", PW'(bias_req), PW'(0));
        check("rst_tile_done", PW'(tile_done), PW'(0));
        check("rst_mtrx_done", PW'(mtrx_done), PW'(0));
    endtask

    // input driver: delayed products for issued addresses, junk otherwise; PPU ready pattern
    initial begin
        for (int i = 0; i < 8; i++) sp_ok[i] = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            prod = sp_ok[cyc % 8] ? sp_val[cyc % 8] : {6{$urandom()}};
            sp_ok[cyc % 8] = 0;
            rdy = (rm == 0) ? 1'b1 : (rm == 1) ? ($urandom % 4 != 0) : (n_beats == 0);
        end
    end

    // monitor: issue order, drain data, handshake hold, pulse tallies
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (prev_valid && !prev_rdy) begin
                check("hold_valid", PW'(acc_valid), PW'(1));
                check("hold_data", acc_data, prev_data);
            end
            if (rd_en) begin
                mon_p = '0;
                if (iss_q.size() == 0) check("extra_issue", PW'(rd_en), PW'(0));
                else begin
                    mon_e = iss_q.pop_front();
                    check("a_addr", PW'(a_addr), PW'(mon_e.a));
                    check("b_addr", PW'(b_addr), PW'(mon_e.b));
                    check("max_pass", PW'(max_pass), PW'(mon_e.mx));
                    if (mon_e.mx) n_max++;
                    mon_p = pvec(mon_e.a, mon_e.b);
                end
                slot = (cyc + RD_LAT) % 8;
                sp_val[slot] = mon_p;
                sp_ok[slot] = 1;
            end
            if (acc_valid && rdy) begin
                n_beats++;
                if (beat_q.size() == 0) check("extra_beat", PW'(acc_valid), PW'(0));
                else check("beat_data", acc_data, beat_q.pop_front());
            end
            n_tdone += int'(tile_done);
            n_mdone += int'(mtrx_done);
            n_bias  += int'(bias_req);
        end
        prev_valid = acc_valid && rst_n;
        prev_rdy   = rdy;
        prev_data  = acc_data;
    end

    initial begin
        logic [1:0] md;
        int r, c, k;
        repeat (3) @(negedge clk);
        zero_checks();
        rst_n = 1;

        // single tile, no MAX pass, all lanes 1
        gen = 1; cval = 1; rm = 0;
        start_job(2, 1, 1, 1, 0);
        wait_idle(1000);
        end_checks(2, 1, 1, 1);

        // INT8: MAX pass then two tiles of 6
        gen = 1; cval = 2;
        start_job(0, 1, 2, 3, 16);
        wait_idle(2000);
        end_checks(0, 1, 2, 3);

        // accumulator wrap: 0x7FFFFF + 0x800001 = 0
        gen = 2;
        start_job(2, 1, 1, 2, 0);
        wait_idle(1000);
        end_checks(2, 1, 1, 2);

        // address walk with random products and ready
        gen = 0; seed = $urandom; rm = 1;
        start_job(0, 2, 2, 4, 32);
        wait_idle(6000);
        end_checks(0, 2, 2, 4);

        // PPU backpressure: third tile must stall while bank 0 is undrained
        gen = 0; seed = $urandom; rm = 2;
        start_job(2, 1, 3, 1, 8);
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("stall_issues_left", PW'(iss_q.size()), PW'(AD));
        check("stall_rd_en", PW'(rd_en), PW'(0));
        check("stall_valid", PW'(acc_valid), PW'(1));
        check("stall_beats", PW'(n_beats), PW'(1));
`ifdef MM_PERF_CNT_EN
        check("stall_cnt_nonzero", PW'(stall_cnt != 0), PW'(1));
`endif
        @(posedge clk); #1;
        start = 1; mode = 0;
        @(posedge clk); #1;
        start = 0; rm = 0;
        wait_idle(2000);
        end_checks(2, 1, 3, 1);

        // reset mid-CALC, then a clean job
        gen = 1; cval = 3;
        start_job(2, 2, 2, 2, 4);
        repeat (40) @(posedge clk);
        #2 rst_n = 0;
        @(negedge clk);
        zero_checks();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) sp_ok[i] = 0;
        iss_q.delete();
        beat_q.delete();
        rst_n = 1;
        gen = 0; seed = $urandom;
        start_job(2, 2, 2, 2, 4);
        wait_idle(3000);
        end_checks(2, 2, 2, 2);

        // random jobs
        for (int j = 0; j < 4; j++) begin
            md = 2'($urandom_range(0, 2));
            r = $urandom_range(1, 2);
            c = $urandom_range(1, 3);
            k = $urandom_range(1, 4);
            gen = 0; seed = $urandom; rm = 1;
            start_job(md, r, c, k, $urandom_range(0, 63));
            wait_idle(6000);
            end_checks(md, r, c, k);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
